// File: rtl/axis_frame_stats.sv
// axis_frame_stats: passive AXI-Stream frame monitor.
// Counts bytes per frame from a popcount of tkeep (or full beats when keep is
// disabled), reports each completed frame's length and flags, and keeps
// running frame-count / min / max statistics. The stream is only observed.
module axis_frame_stats #(
  parameter int KEEP_WIDTH  = 8,
  parameter int KEEP_ENABLE = 1,
  parameter int LEN_WIDTH   = 16,
  parameter int COUNT_WIDTH = 32,
  parameter int MIN_LEN     = 60,
  parameter int MAX_LEN     = 1518
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [KEEP_WIDTH-1:0]  monitor_axis_tkeep,
  input  logic                   monitor_axis_tvalid,
  input  logic                   monitor_axis_tready,
  input  logic                   monitor_axis_tlast,
  input  logic                   stat_clear,
  output logic [LEN_WIDTH-1:0]   frame_len,
  output logic                   frame_len_valid,
  output logic                   frame_runt,
  output logic                   frame_oversize,
  output logic                   frame_saturated,
  output logic [COUNT_WIDTH-1:0] stat_frame_count,
  output logic [LEN_WIDTH-1:0]   stat_min_len,
  output logic [LEN_WIDTH-1:0]   stat_max_len
);

  localparam int BYTES_W = $clog2(KEEP_WIDTH + 1);
  // Sum is one bit wider than the larger operand so an overflow is visible
  // before clamping, even when a single beat could exceed the length range.
  localparam int SUM_W   = ((LEN_WIDTH > BYTES_W) ? LEN_WIDTH : BYTES_W) + 1;
  // Threshold compares are done wide enough to hold both the length and a
  // 32-bit integer threshold without truncating either.
  localparam int CMP_W   = (LEN_WIDTH > 32) ? (LEN_WIDTH + 1) : 33;

  localparam logic [LEN_WIDTH-1:0]   LEN_ONES   = '1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONES = '1;
  localparam logic [SUM_W-1:0]       LEN_MAX_W  = SUM_W'(LEN_ONES);
  localparam logic [CMP_W-1:0]       MIN_C      = CMP_W'(MIN_LEN);
  localparam logic [CMP_W-1:0]       MAX_C      = CMP_W'(MAX_LEN);

  // Frame tracking state
  logic                   in_frame_q, in_frame_d;
  logic [LEN_WIDTH-1:0]   acc_q, acc_d;
  logic                   sat_q, sat_d;

  // Per-frame result registers
  logic [LEN_WIDTH-1:0]   frame_len_q, frame_len_d;
  logic                   frame_len_valid_q, frame_len_valid_d;
  logic                   frame_runt_q, frame_runt_d;
  logic                   frame_oversize_q, frame_oversize_d;
  logic                   frame_saturated_q, frame_saturated_d;

  // Running statistics
  logic [COUNT_WIDTH-1:0] stat_frame_count_q, stat_frame_count_d;
  logic [LEN_WIDTH-1:0]   stat_min_len_q, stat_min_len_d;
  logic [LEN_WIDTH-1:0]   stat_max_len_q, stat_max_len_d;

  logic                   beat;
  logic [BYTES_W-1:0]     beat_bytes;
  logic [SUM_W-1:0]       sum_wide;
  logic                   sum_overflow;
  logic [LEN_WIDTH-1:0]   sum_len;
  logic                   sat_now;
  logic                   runt_now;
  logic                   oversize_now;

  assign beat = monitor_axis_tvalid & monitor_axis_tready;

  // Bytes carried by this beat: popcount of tkeep, or a full beat when keep is ignored
  always_comb begin
    beat_bytes = '0;
    if (KEEP_ENABLE != 0) begin
      for (int i = 0; i < KEEP_WIDTH; i++) begin
        beat_bytes = beat_bytes + BYTES_W'(monitor_axis_tkeep[i]);
      end
    end else begin
      beat_bytes = BYTES_W'(KEEP_WIDTH);
    end
  end

  // Running sum with clamping; the first beat of a frame restarts the count
  always_comb begin
    if (in_frame_q) begin
      sum_wide = SUM_W'(acc_q) + SUM_W'(beat_bytes);
    end else begin
      sum_wide = SUM_W'(beat_bytes);
    end
    sum_overflow = (sum_wide > LEN_MAX_W);
    sum_len      = sum_overflow ? LEN_ONES : sum_wide[LEN_WIDTH-1:0];
    sat_now      = sum_overflow | (in_frame_q & sat_q);
    runt_now     = (CMP_W'(sum_len) < MIN_C);
    oversize_now = (CMP_W'(sum_len) > MAX_C);
  end

  // Next-state for frame tracking, per-frame results and statistics
  always_comb begin
    in_frame_d         = in_frame_q;
    acc_d              = acc_q;
    sat_d              = sat_q;
    frame_len_d        = frame_len_q;
    frame_len_valid_d  = 1'b0;
    frame_runt_d       = frame_runt_q;
    frame_oversize_d   = frame_oversize_q;
    frame_saturated_d  = frame_saturated_q;

    // A clear is applied first so a frame ending in the same cycle is counted
    // against freshly cleared statistics.
    if (stat_clear) begin
      stat_frame_count_d = '0;
      stat_min_len_d     = LEN_ONES;
      stat_max_len_d     = '0;
    end else begin
      stat_frame_count_d = stat_frame_count_q;
      stat_min_len_d     = stat_min_len_q;
      stat_max_len_d     = stat_max_len_q;
    end

    if (beat) begin
      if (monitor_axis_tlast) begin
        frame_len_d       = sum_len;
        frame_len_valid_d = 1'b1;
        frame_runt_d      = runt_now;
        frame_oversize_d  = oversize_now;
        frame_saturated_d = sat_now;
        in_frame_d        = 1'b0;
        acc_d             = '0;
        sat_d             = 1'b0;

        if (stat_frame_count_d != COUNT_ONES) begin
          stat_frame_count_d = stat_frame_count_d + COUNT_WIDTH'(1);
        end
        if (sum_len < stat_min_len_d) begin
          stat_min_len_d = sum_len;
        end
        if (sum_len > stat_max_len_d) begin
          stat_max_len_d = sum_len;
        end
      end else begin
        in_frame_d = 1'b1;
        acc_d      = sum_len;
        sat_d      = sat_now;
      end
    end
  end

  // State registers; reset overrides clear and any beat in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      in_frame_q         <= 1'b0;
      acc_q              <= '0;
      sat_q              <= 1'b0;
      frame_len_q        <= '0;
      frame_len_valid_q  <= 1'b0;
      frame_runt_q       <= 1'b0;
      frame_oversize_q   <= 1'b0;
      frame_saturated_q  <= 1'b0;
      stat_frame_count_q <= '0;
      stat_min_len_q     <= LEN_ONES;
      stat_max_len_q     <= '0;
    end else begin
      in_frame_q         <= in_frame_d;
      acc_q              <= acc_d;
      sat_q              <= sat_d;
      frame_len_q        <= frame_len_d;
      frame_len_valid_q  <= frame_len_valid_d;
      frame_runt_q       <= frame_runt_d;
      frame_oversize_q   <= frame_oversize_d;
      frame_saturated_q  <= frame_saturated_d;
      stat_frame_count_q <= stat_frame_count_d;
      stat_min_len_q     <= stat_min_len_d;
      stat_max_len_q     <= stat_max_len_d;
    end
  end

  assign frame_len        = frame_len_q;
  assign frame_len_valid  = frame_len_valid_q;
  assign frame_runt       = frame_runt_q;
  assign frame_oversize   = frame_oversize_q;
  assign frame_saturated  = frame_saturated_q;
  assign stat_frame_count = stat_frame_count_q;
  assign stat_min_len     = stat_min_len_q;
  assign stat_max_len     = stat_max_len_q;

endmodule

// File: tb/tb_axis_frame_stats.sv
// Testbench for axis_frame_stats: default instance driven by directed and
// random beats against a frame-level reference model, plus two directed
// instances for the narrow-length and keep-disabled configurations.
module tb_axis_frame_stats;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Default-parameter instance
  logic        rst0, clr0, v0, r0, l0;
  logic [7:0]  k0;
  logic [15:0] len0, min0, max0;
  logic        vld0, runt0, ovs0, sat0;
  logic [31:0] cnt0;

  axis_frame_stats dut0 (
    .clk(clk), .rst(rst0), .monitor_axis_tkeep(k0), .monitor_axis_tvalid(v0),
    .monitor_axis_tready(r0), .monitor_axis_tlast(l0), .stat_clear(clr0),
    .frame_len(len0), .frame_len_valid(vld0), .frame_runt(runt0),
    .frame_oversize(ovs0), .frame_saturated(sat0), .stat_frame_count(cnt0),
    .stat_min_len(min0), .stat_max_len(max0)
  );

  // LEN_WIDTH=8 instance
  logic        rst8, clr8, v8, r8, l8;
  logic [7:0]  k8;
  logic [7:0]  len8, min8, max8;
  logic        vld8, runt8, ovs8, sat8;
  logic [31:0] cnt8;

  axis_frame_stats #(.LEN_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .monitor_axis_tkeep(k8), .monitor_axis_tvalid(v8),
    .monitor_axis_tready(r8), .monitor_axis_tlast(l8), .stat_clear(clr8),
    .frame_len(len8), .frame_len_valid(vld8), .frame_runt(runt8),
    .frame_oversize(ovs8), .frame_saturated(sat8), .stat_frame_count(cnt8),
    .stat_min_len(min8), .stat_max_len(max8)
  );

  // KEEP_ENABLE=0, KEEP_WIDTH=4 instance
  logic        rstk, clrk, vk, rk, lk;
  logic [3:0]  kk;
  logic [15:0] lenk, mink, maxk;
  logic        vldk, runtk, ovsk, satk;
  logic [31:0] cntk;

  axis_frame_stats #(.KEEP_WIDTH(4), .KEEP_ENABLE(0)) dutk (
    .clk(clk), .rst(rstk), .monitor_axis_tkeep(kk), .monitor_axis_tvalid(vk),
    .monitor_axis_tready(rk), .monitor_axis_tlast(lk), .stat_clear(clrk),
    .frame_len(lenk), .frame_len_valid(vldk), .frame_runt(runtk),
    .frame_oversize(ovsk), .frame_saturated(satk), .stat_frame_count(cntk),
    .stat_min_len(mink), .stat_max_len(maxk)
  );

  // Reference model of dut0: true byte total of the open frame plus reported results
  bit          m_in;
  int          m_total;
  logic [15:0] m_len, m_min, m_max;
  bit          m_vld, m_runt, m_ovs, m_sat;
  logic [31:0] m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cyc0(input logic [7:0] k, input bit v, input bit r, input bit l,
                      input bit clr, input bit rs);
    @(negedge clk);
    k0 = k; v0 = v; r0 = r; l0 = l; clr0 = clr; rst0 = rs;
    @(posedge clk);
    if (rs) begin
      m_in = 0; m_total = 0; m_len = 16'd0; m_vld = 0; m_runt = 0; m_ovs = 0;
      m_sat = 0; m_cnt = 32'd0; m_min = 16'hFFFF; m_max = 16'd0;
    end else begin
      m_vld = 0;
      if (clr) begin
        m_cnt = 32'd0; m_min = 16'hFFFF; m_max = 16'd0;
      end
      if (v && r) begin
        m_total = (m_in ? m_total : 0) + $countones(k);
        if (l) begin
          m_sat  = (m_total > 65535);
          m_len  = m_sat ? 16'hFFFF : 16'(m_total);
          m_runt = (m_len < 16'd60);
          m_ovs  = (m_len > 16'd1518);
          m_vld  = 1;
          if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
          if (m_len < m_min) m_min = m_len;
          if (m_len > m_max) m_max = m_len;
          m_in = 0;
        end else begin
          m_in = 1;
        end
      end
    end
    #1;
    chk("frame_len",       64'(len0),  64'(m_len));
    chk("frame_len_valid", 64'(vld0),  64'(m_vld));
    chk("frame_runt",      64'(runt0), 64'(m_runt));
    chk("frame_oversize",  64'(ovs0),  64'(m_ovs));
    chk("frame_saturated", 64'(sat0),  64'(m_sat));
    chk("stat_frame_count",64'(cnt0),  64'(m_cnt));
    chk("stat_min_len",    64'(min0),  64'(m_min));
    chk("stat_max_len",    64'(max0),  64'(m_max));
  endtask

  initial begin
    rst0 = 1; clr0 = 0; v0 = 0; r0 = 0; l0 = 0; k0 = 8'h00;
    rst8 = 1; clr8 = 0; v8 = 0; r8 = 0; l8 = 0; k8 = 8'h00;
    rstk = 1; clrk = 0; vk = 0; rk = 0; lk = 0; kk = 4'h0;

    // Reset values
    cyc0(8'h00, 0, 0, 0, 0, 1);
    cyc0(8'h00, 0, 0, 0, 0, 1);
    rst8 = 0; rstk = 0;
    cyc0(8'h00, 0, 0, 0, 0, 0);

    // 8 full beats + 0x0F last -> 68 bytes, one-cycle valid
    for (int i = 0; i < 8; i++) cyc0(8'hFF, 1, 1, 0, 0, 0);
    cyc0(8'h0F, 1, 1, 1, 0, 0);
    cyc0(8'h00, 0, 0, 0, 0, 0);
    chk("len68_direct", 64'(len0), 64'd68);

    // Clear, then non-contiguous keep single beat, then back-to-back 3-beat frame
    cyc0(8'h00, 0, 0, 0, 1, 0);
    cyc0(8'hA5, 1, 1, 1, 0, 0);
    chk("noncontig_len", 64'(len0), 64'd4);
    for (int i = 0; i < 3; i++) cyc0(8'hFF, 1, 1, (i == 2), 0, 0);
    chk("noncontig_min", 64'(min0), 64'd4);
    chk("noncontig_max", 64'(max0), 64'd24);

    // Zero-byte frame
    cyc0(8'h00, 1, 1, 0, 0, 0);
    cyc0(8'h00, 1, 1, 1, 0, 0);

    // 190 full beats -> 1520 bytes, oversize
    for (int i = 0; i < 190; i++) cyc0(8'hFF, 1, 1, (i == 189), 0, 0);
    chk("oversize_1520", 64'(ovs0), 64'd1);

    // Reset mid-frame, then a 2-byte frame
    for (int i = 0; i < 3; i++) cyc0(8'hFF, 1, 1, 0, 0, 0);
    cyc0(8'h00, 0, 0, 0, 0, 1);
    cyc0(8'h03, 1, 1, 1, 0, 0);
    chk("post_reset_cnt", 64'(cnt0), 64'd1);

    // Count up to 5 with back-to-back single-beat frames, then clear on a 64-byte last beat
    cyc0(8'h00, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc0(8'h01, 1, 1, 1, 0, 0);
    for (int i = 0; i < 8; i++) cyc0(8'hFF, 1, 1, (i == 7), (i == 7), 0);
    chk("clear_last_cnt", 64'(cnt0), 64'd1);
    chk("clear_last_min", 64'(min0), 64'd64);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc0(8'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0),
           ($urandom_range(0, 255) == 0));
    end

    // LEN_WIDTH=8: 40 full beats saturate at 255
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); k8 = 8'hFF; v8 = 1; r8 = 1; l8 = (i == 39);
    end
    @(negedge clk); v8 = 0; l8 = 0;
    chk("w8_len_sat",   64'(len8), 64'd255);
    chk("w8_sat_flag",  64'(sat8), 64'd1);
    chk("w8_valid",     64'(vld8), 64'd1);
    chk("w8_runt",      64'(runt8), 64'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); k8 = 8'hFF; v8 = 1; r8 = 1; l8 = (i == 1);
    end
    @(negedge clk); v8 = 0; l8 = 0;
    chk("w8_len16",     64'(len8), 64'd16);
    chk("w8_sat_clear", 64'(sat8), 64'd0);
    chk("w8_runt16",    64'(runt8), 64'd1);
    chk("w8_cnt",       64'(cnt8), 64'd2);
    chk("w8_min",       64'(min8), 64'd16);
    chk("w8_max",       64'(max8), 64'd255);
    @(negedge clk);
    chk("w8_valid_drop",64'(vld8), 64'd0);

    // KEEP_ENABLE=0, KEEP_WIDTH=4: 16 beats with tkeep=0 count 64 bytes
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); kk = 4'h0; vk = 1; rk = 1; lk = (i == 15);
    end
    @(negedge clk); vk = 0; lk = 0;
    chk("nk_len",   64'(lenk), 64'd64);
    chk("nk_valid", 64'(vldk), 64'd1);
    chk("nk_runt",  64'(runtk), 64'd0);
    chk("nk_cnt",   64'(cntk), 64'd1);
    // tvalid without tready must not change anything
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); kk = 4'hF; vk = 1; rk = 0; lk = 1;
      chk("nk_noready_valid", 64'(vldk), 64'd0);
      chk("nk_noready_len",   64'(lenk), 64'd64);
      chk("nk_noready_cnt",   64'(cntk), 64'd1);
    end
    @(negedge clk); vk = 0; lk = 0;
    chk("nk_hold_valid", 64'(vldk), 64'd0);
    chk("nk_hold_min",   64'(mink), 64'd64);
    chk("nk_hold_max",   64'(maxk), 64'd64);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_frame_stats.md
# axis_frame_stats

Passive AXI-Stream frame monitor: the parametrised successor to the single-width frame length counter. It taps a stream's handshake and tkeep without driving it, and counts the bytes in every frame using a popcount of tkeep, so non-contiguous keep patterns are counted correctly. For each completed frame it reports the length, saturation, runt and oversize flags. It also keeps running statistics (frame count, minimum and maximum length) for the MAC/statistics blocks downstream.

## Interface
Parameters:
- KEEP_WIDTH, 8, number of tkeep lanes (bytes per beat); must be ≥1.
- KEEP_ENABLE, 1, when 0 tkeep is ignored and every beat counts KEEP_WIDTH bytes.
- LEN_WIDTH, 16, width of the frame length and the min/max statistics.
- COUNT_WIDTH, 32, width of the frame counter.
- MIN_LEN, 60, frames shorter than this are flagged runt.
- MAX_LEN, 1518, frames longer than this are flagged oversize.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- monitor_axis_tkeep  in  KEEP_WIDTH  byte-enable lanes of the monitored stream.
- monitor_axis_tvalid  in  1  monitored tvalid.
- monitor_axis_tready  in  1  monitored tready.
- monitor_axis_tlast  in  1  monitored tlast.
- stat_clear  in  1  synchronous clear of the statistics.
- frame_len  out  LEN_WIDTH  byte length of the last completed frame.
- frame_len_valid  out  1  one-cycle pulse: frame_len and the flags are new.
- frame_runt  out  1  last frame length < MIN_LEN.
- frame_oversize  out  1  last frame length > MAX_LEN.
- frame_saturated  out  1  last frame's length count saturated.
- stat_frame_count  out  COUNT_WIDTH  frames completed since reset or clear.
- stat_min_len  out  LEN_WIDTH  minimum completed frame length.
- stat_max_len  out  LEN_WIDTH  maximum completed frame length.

## Operation
- Beat = tvalid & tready. Cycles without a beat change nothing except the frame_len_valid deassertion.
- Beat bytes:
  - KEEP_ENABLE=1: popcount(tkeep), range 0..KEEP_WIDTH, any bit pattern.
  - KEEP_ENABLE=0: KEEP_WIDTH.
- State: in_frame (1 bit), acc (LEN_WIDTH), sat (sticky per frame).
- Running sum:
  - When in_frame=0, sum = bytes, and sat is cleared for the new frame.
  - When in_frame=1, sum = acc + bytes, computed at LEN_WIDTH+1 bits.
  - If sum > 2^LEN_WIDTH−1, the result is clamped to all ones and sat is set.
  - The length is therefore restarted at the first beat of every frame, including single-beat frames.
- Non-last beat: acc ← sum, in_frame ← 1.
- Last beat:
  - frame_len ← sum; frame_saturated ← sat (including this beat).
  - frame_runt ← (sum < MIN_LEN); frame_oversize ← (sum > MAX_LEN).
  - frame_len_valid ← 1; in_frame ← 0; acc ← 0.
  - stat_frame_count increments, saturating at all ones.
  - stat_min_len ← min(stat_min_len, sum); stat_max_len ← max(stat_max_len, sum).
- frame_len and the three flags hold their values until the next last beat.
- stat_clear:
  - Sets stat_frame_count ← 0, stat_min_len ← all ones, stat_max_len ← 0.
  - If a last beat occurs in the same cycle, the clear is applied first and that frame is then counted: count = 1, min = max = sum.
  - stat_clear does not affect frame tracking or the frame_* outputs.
- Zero-byte frames (all beats tkeep=0) report length 0, are counted, and set frame_runt if MIN_LEN > 0.

## Timing
- All outputs are registered.
- frame_len_valid goes high in the cycle after the edge that samples the last beat, for exactly one cycle. Back-to-back single-beat frames produce consecutive pulses.
- Statistics update on the same edge as frame_len.
- Reset values:
  - frame_len = 0.
  - frame_len_valid, frame_runt, frame_oversize and frame_saturated = 0.
  - stat_frame_count = 0, stat_min_len = all ones, stat_max_len = 0.
  - in_frame = 0, acc = 0.
- Reset mid-frame discards the partial frame. The first beat after reset starts a new frame.
- Reset takes priority over stat_clear and over beats in the same cycle.
- The block never drives the stream; there is no backpressure.

## Test plan
- Defaults; frame of 8 beats with tkeep=0xFF, then 1 beat with tkeep=0x0F+tlast → frame_len=68, one-cycle valid, runt=0, oversize=0, stat_frame_count=1, min=max=68.
- Non-contiguous keep: single beat with tkeep=0xA5+tlast → frame_len=4 and runt=1. Immediately after, a 3-beat frame of tkeep=0xFF → second valid pulse with frame_len=24, min=4, max=24.
- LEN_WIDTH=8: 40 beats of tkeep=0xFF → frame_len=255, frame_saturated=1. The next 2-beat frame of 0xFF → frame_len=16, saturated=0.
- 190 beats of 0xFF (1520 bytes) → oversize=1. Then reset asserted mid-frame after 3 beats, followed by a 1-beat frame with tkeep=0x03 → frame_len=2, count=1, min=max=2.
- stat_clear coincident with a last beat of a 64-byte frame, with prior count=5 → count=1, min=max=64.
- KEEP_ENABLE=0, KEEP_WIDTH=4: 16 beats with tkeep=0 → frame_len=64. tvalid without tready for 10 cycles → no change to any output.
